// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM state encoding and index-placement defaults for the
// load/store sequencer.
package mem_access_pkg;

    localparam int INDEX_LSB_DEF = 27;
    localparam int INDEX_W_DEF   = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Illegal size code, or a halfword/word not naturally aligned.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
        return (size == SZ_ILL) ||
               (size == SZ_HALF && lane[0]) ||
               (size == SZ_WORD && lane != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake towards the datapath plus the word-memory port.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        stall;

    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
               mem_readData,
        output req_ready, resp_valid, resp_rdata, resp_error, stall,
               mem_address, mem_writeData, mem_memWrite, mem_memRead
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
               mem_readData,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall,
               mem_address, mem_writeData, mem_memWrite, mem_memRead
    );

endinterface

// File: rtl/mem_access_unit_subword_align.sv
// Lane handling: merges store data into a word and aligns/extends load data.
module subword_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
    assign half_sel = word_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        merged_o = word_i;
        load_o   = word_i;
        case (size_i)
            SZ_BYTE: begin
                merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = {{16{signed_i & half_sel[15]}}, half_sel};
            end
            default: begin
                merged_o = wdata_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns byte/half/word requests into word-memory
// accesses, using read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int INDEX_LSB = INDEX_LSB_DEF,
    parameter int INDEX_W   = INDEX_W_DEF
) (
    input logic              clock_in,
    input logic              reset,
    mem_access_unit_if.slave bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] merged;
    logic [31:0] load_val;

    // Memory read data is only meaningful in READ, where both results are consumed.
    subword_align u_align (
        .word_i   (bus.mem_readData),
        .lane_i   (lane_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .merged_o (merged),
        .load_o   (load_val)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    lane_d   = bus.req_addr[1:0];
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    write_d  = bus.req_write;
                    wdata_d  = bus.req_wdata;
                    if (is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else begin
                        mem_addr_d = '0;
                        mem_addr_d[INDEX_LSB +: INDEX_W] = bus.req_addr[2 +: INDEX_W];
                        if (bus.req_write && bus.req_size == SZ_WORD) begin
                            state_d     = S_WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            state_d    = S_READ;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            S_READ: begin
                if (write_q) begin
                    state_d     = S_WRITE;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_val;
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d      = S_IDLE;
                resp_error_d = 1'b0;
                resp_rdata_d = '0;
                mem_addr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Request capture registers carry data only; the FSM decides when they matter.
    always_ff @(posedge clock_in) begin
        lane_q   <= lane_d;
        size_q   <= size_d;
        signed_q <= signed_d;
        write_q  <= write_d;
        wdata_q  <= wdata_d;
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.stall         = (state_q != S_IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_error    = resp_error_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.mem_memRead   = mem_read_q;
    assign bus.mem_memWrite  = mem_write_q;
    assign bus.mem_address   = mem_addr_q;
    assign bus.mem_writeData = mem_wdata_q;

endmodule
